aoc_line_parser: RTL and testbench
==================================

# aoc_line_parser

Upstream input stage for the dial-rotation solver. Consumes the raw puzzle text as a byte stream (lines such as `L68`, `R5`), decodes each line into one rotation command, and drives the solver's `valid` / `step_direction` / `step_count` inputs with a single-cycle strobe per line. It sits between the byte source (UART/ROM reader) and `solution`, and is always ready: it never back-pressures the source.

## Interface
Parameters:
- `COUNT_W`, default 10: width of `step_count`; it matches the solver's 10-bit input.
- `MAX_DIGITS`, default 4: maximum number of decimal digits accepted per line.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_data` carries a byte this cycle.
- `in_data`  in  8: ASCII byte.
- `in_last`  in  1: qualifies the final byte of the input, sampled only with `in_valid`.
- `valid`  out  1: one-cycle strobe; a decoded command is present.
- `step_direction`  out  1: 1 = `R`, 0 = `L`; valid only with `valid`.
- `step_count`  out  `COUNT_W`: decoded magnitude; valid only with `valid`.
- `done`  out  1: sticky; set after the `in_last` byte has been processed.
- `parse_error`  out  1: sticky; exists only when `AOC_PARSER_ERR_EN` is defined.

## Operation
- FSM states:
  - IDLE: expects a direction letter.
  - DIGITS: accumulates the number.
  - SKIP: discards bytes to the next newline; only present with error logic.
  - DONE.
- IDLE transitions:
  - `L` or `R` → latch the direction, clear the accumulator and digit counter, go to DIGITS.
  - `\n` or `\r` → stay in IDLE (blank lines are ignored).
  - Any other byte → malformed.
- DIGITS transitions:
  - `0`–`9` → `acc = acc*10 + digit`, computed as `(acc<<3)+(acc<<1)+d` in a `COUNT_W+4`-bit intermediate. Digit counter increments.
  - `\n` → emit a command, go to IDLE.
  - `\r` → ignored.
  - Any other byte → malformed.
- Overflow: an intermediate value above 2^`COUNT_W`−1, or more than `MAX_DIGITS` digits, is malformed.
- Zero digits before `\n` (e.g. `L\n`) is malformed.
- Malformed handling without error logic:
  - Bad byte: ignored, state unchanged.
  - Overflow: `acc` saturates at 1023.
  - Zero-digit line: emits count 0.
- `in_last` with `in_valid`:
  - The byte is processed first.
  - If the FSM is still in DIGITS with at least one digit, the command is emitted as if a newline had been received.
  - The FSM then enters DONE and `done` is set.
  - DONE ignores all further input until reset.
- Leading zeros are accepted (`R007` → 7).

## Timing
- Reset values: `valid`=0, `step_direction`=0, `step_count`=0, `done`=0, `parse_error`=0, FSM=IDLE, accumulator=0.
- Latency: `valid` is registered and asserts on the cycle after the terminating byte (`\n`, or the `in_last` byte) is accepted. `step_count` and `step_direction` are stable in that cycle.
- `valid` is never high for two consecutive cycles per line. Back-to-back lines at one byte per cycle give at most one strobe every 3 cycles, because the shortest line is `R1\n`.
- `done` asserts in the same cycle as the final `valid`, or one cycle after the `in_last` byte if nothing is emitted.
- `in_valid` low: no state change. Gaps between bytes are allowed anywhere.
- Reset mid-line: the partial command is discarded and no strobe is produced. An asynchronous assert clears all outputs immediately.

## Configuration
`AOC_PARSER_ERR_EN`:
- Defined:
  - `parse_error` port exists.
  - Any malformed condition sets `parse_error` (sticky until reset) and moves the FSM to SKIP.
  - SKIP drops bytes until `\n`, then returns to IDLE. No command is emitted for that line.
  - `in_last` in SKIP goes to DONE without emitting.
- Undefined: no port and no SKIP state; malformed input is handled as described under Operation.

## Structure
- Shared package `aoc_pkg`:
  - ASCII constants: `ASCII_L`, `ASCII_R`, `ASCII_0`, `ASCII_9`, `ASCII_LF`, `ASCII_CR`.
  - FSM state encoding.
  - `STEP_COUNT_W` = 10, shared with `solution` and `top`.
- One sub-module, `aoc_dec_accum`: the decimal multiply-accumulate with saturation and overflow flag, plus the digit counter.

## Test plan
- Bytes `L68\nR30\n` → two strobes: (dir 0, count 68), then (dir 1, count 30). Each strobe one cycle after its `\n`; no other `valid` cycles.
- `R999` with `in_last` on `9`, and no newline → one strobe (1, 999); `done`=1 in the same cycle; later bytes `L5\n` produce nothing.
- `\n\r\nL0\r\nR007\n` with random `in_valid` gaps → strobes (0, 0) and (1, 7) only.
- `R1500\n`:
  - ERR_EN off → strobe (1, 1023).
  - ERR_EN on → no strobe, `parse_error`=1, and the following `L2\n` → strobe (0, 2).
- `LX4\n`:
  - ERR_EN off → strobe (0, 4).
  - ERR_EN on → `parse_error`=1, no strobe.
- `rst_n` pulsed low after `R12` → no strobe, all outputs 0; then `L3\n` → strobe (0, 3).

Source files
------------

// File: rtl/aoc_pkg.sv
// aoc_pkg: ASCII byte codes, parser FSM encoding and step-count width shared
// by the puzzle-input parser and the dial solver.
`default_nettype none

package aoc_pkg;

    localparam int STEP_COUNT_W = 10;

    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIGITS = 2'd1,
        ST_SKIP   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/aoc_dec_accum.sv
// aoc_dec_accum: saturating decimal multiply-accumulate with digit counter.
// Overflow flag port exists only when AOC_PARSER_ERR_EN is defined.
`default_nettype none

module aoc_dec_accum
    import aoc_pkg::*;
#(
    parameter int COUNT_W    = STEP_COUNT_W,
    parameter int MAX_DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               digit_en,
    input  logic [3:0]         digit,
    output logic [COUNT_W-1:0] acc_next,
    output logic               has_digit_next
`ifdef AOC_PARSER_ERR_EN
    ,
    output logic               overflow
`endif
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam logic [COUNT_W-1:0] SAT = '1;

    logic [COUNT_W-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [COUNT_W+3:0] wide;
    logic               cnt_full;
    logic               ovf;

    // acc*10 + d without a multiplier; 4 spare bits hold the worst case 10*SAT+9
    always_comb begin
        wide     = ({4'b0, acc} << 3) + ({4'b0, acc} << 1) + {{COUNT_W{1'b0}}, digit};
        cnt_full = (cnt == CNT_W'(MAX_DIGITS));
        ovf      = digit_en && (cnt_full || (wide > {4'b0, SAT}));
        acc_next = acc;
        cnt_next = cnt;
        if (clear) begin
            acc_next = '0;
            cnt_next = '0;
        end else if (digit_en) begin
            acc_next = ovf ? SAT : wide[COUNT_W-1:0];
            if (!cnt_full) begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
        has_digit_next = (cnt_next != '0);
    end

`ifdef AOC_PARSER_ERR_EN
    assign overflow = ovf;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/aoc_line_parser.sv
// aoc_line_parser: decodes "L68\n"-style byte lines into one-cycle rotation strobes.
// Optional AOC_PARSER_ERR_EN adds the sticky parse_error port and the SKIP state.
`default_nettype none

module aoc_line_parser
    import aoc_pkg::*;
#(
    parameter int COUNT_W    = STEP_COUNT_W,
    parameter int MAX_DIGITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    input  logic               in_last,
    output logic               valid,
    output logic               step_direction,
    output logic [COUNT_W-1:0] step_count,
    output logic               done
`ifdef AOC_PARSER_ERR_EN
    ,
    output logic               parse_error
`endif
);

    state_t             state;
    state_t             line_nxt;
    state_t             nxt_state;
    logic               dir_q;
    logic               emit;
    logic               is_dir;
    logic               is_nl;
    logic               is_cr;
    logic               is_digit;
    logic               clear;
    logic               digit_en;
    logic [COUNT_W-1:0] acc_next;
    logic               has_digit_next;
`ifdef AOC_PARSER_ERR_EN
    logic               overflow;
    logic               err_set;
`endif

    assign is_dir   = (in_data == ASCII_L) || (in_data == ASCII_R);
    assign is_nl    = (in_data == ASCII_LF);
    assign is_cr    = (in_data == ASCII_CR);
    assign is_digit = (in_data >= ASCII_0) && (in_data <= ASCII_9);
    assign clear    = in_valid && (state == ST_IDLE) && is_dir;
    assign digit_en = in_valid && (state == ST_DIGITS) && is_digit;

    aoc_dec_accum #(
        .COUNT_W    (COUNT_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_accum (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear),
        .digit_en       (digit_en),
        .digit          (in_data[3:0]),
        .acc_next       (acc_next),
        .has_digit_next (has_digit_next)
`ifdef AOC_PARSER_ERR_EN
        ,
        .overflow       (overflow)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // line_nxt is where the byte alone leads; in_last then overrides to DONE
    always_comb begin
        line_nxt = state;
`ifdef AOC_PARSER_ERR_EN
        err_set  = 1'b0;
`endif
        if (in_valid) begin
            case (state)
                ST_IDLE: begin
                    if (is_dir) begin
                        line_nxt = ST_DIGITS;
                    end else if (!is_nl && !is_cr) begin
`ifdef AOC_PARSER_ERR_EN
                        line_nxt = ST_SKIP;
                        err_set  = 1'b1;
`endif
                    end
                end
                ST_DIGITS: begin
                    if (is_digit) begin
`ifdef AOC_PARSER_ERR_EN
                        if (overflow) begin
                            line_nxt = ST_SKIP;
                            err_set  = 1'b1;
                        end
`endif
                    end else if (is_nl) begin
                        line_nxt = ST_IDLE;
`ifdef AOC_PARSER_ERR_EN
                        err_set  = !has_digit_next;
`endif
                    end else if (!is_cr) begin
`ifdef AOC_PARSER_ERR_EN
                        line_nxt = ST_SKIP;
                        err_set  = 1'b1;
`endif
                    end
                end
`ifdef AOC_PARSER_ERR_EN
                ST_SKIP: begin
                    if (is_nl) begin
                        line_nxt = ST_IDLE;
                    end
                end
`endif
                default: ;
            endcase
        end
        nxt_state = line_nxt;
        if (in_valid && in_last && (state != ST_DONE)) begin
            nxt_state = ST_DONE;
        end
    end

    always_comb begin
        emit = 1'b0;
        if (in_valid && (state == ST_DIGITS)) begin
            if (is_nl) begin
`ifdef AOC_PARSER_ERR_EN
                emit = has_digit_next;
`else
                emit = 1'b1;
`endif
            end else if (in_last && (line_nxt == ST_DIGITS) && has_digit_next) begin
                emit = 1'b1;
            end
        end
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid          <= 1'b0;
            step_direction <= 1'b0;
            step_count     <= '0;
            dir_q          <= 1'b0;
`ifdef AOC_PARSER_ERR_EN
            parse_error    <= 1'b0;
`endif
        end else begin
            valid <= emit;
            if (emit) begin
                step_count     <= acc_next;
                step_direction <= dir_q;
            end
            if (clear) begin
                dir_q <= (in_data == ASCII_R);
            end
`ifdef AOC_PARSER_ERR_EN
            if (err_set) begin
                parse_error <= 1'b1;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aoc_line_parser.sv
// tb_aoc_line_parser: directed byte streams against a line-level parsing model.
// Build with AOC_PARSER_ERR_EN defined to exercise the error-handling variant.
`default_nettype none

module tb_aoc_line_parser;

    localparam int MAX_DIGITS = 4;
    localparam int SAT        = 1023;
`ifdef AOC_PARSER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       valid;
    logic       step_direction;
    logic [9:0] step_count;
    logic       done;
`ifdef AOC_PARSER_ERR_EN
    logic       parse_error;
`endif

    always #5 clk = ~clk;

    aoc_line_parser #(
        .COUNT_W    (10),
        .MAX_DIGITS (MAX_DIGITS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .valid          (valid),
        .step_direction (step_direction),
        .step_count     (step_count),
        .done           (done)
`ifdef AOC_PARSER_ERR_EN
        ,
        .parse_error    (parse_error)
`endif
    );

    typedef struct {
        bit dir;
        int cnt;
        int cyc;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t seen_q[$];
    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;
    string   line_buf = "";
    bit      model_done = 1'b0;
    int      done_cyc = -1;
    bit      exp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Whole-line interpretation of the text rules; nl=0 means the line ended on in_last.
    function automatic void eval_line(input string s, input bit nl, input int ecyc);
        bit         seen_dir = 1'b0;
        bit         d = 1'b0;
        bit         sat = 1'b0;
        int         nd = 0;
        longint     v = 0;
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            if (!seen_dir) begin
                if (c == "L" || c == "R") begin
                    seen_dir = 1'b1;
                    d = (c == "R");
                end else if (c != 8'h0D && ERR_EN) begin
                    exp_err = 1'b1;
                    return;
                end
            end else if (c >= "0" && c <= "9") begin
                nd++;
                if (!sat) v = v * 10 + longint'(c - "0");
                if (v > SAT || nd > MAX_DIGITS) begin
                    if (ERR_EN) begin
                        exp_err = 1'b1;
                        return;
                    end
                    sat = 1'b1;
                end
            end else if (c != 8'h0D && ERR_EN) begin
                exp_err = 1'b1;
                return;
            end
        end
        if (!seen_dir) return;
        if (nd == 0) begin
            if (!nl) return;
            if (ERR_EN) begin
                exp_err = 1'b1;
                return;
            end
        end
        exp_q.push_back('{d, sat ? SAT : int'(v), ecyc});
    endfunction

    task automatic model_byte(input logic [7:0] b, input bit last);
        if (model_done) return;
        if (b == 8'h0A) begin
            eval_line(line_buf, 1'b1, cyc + 1);
            line_buf = "";
        end else begin
            line_buf = $sformatf("%s%c", line_buf, b);
            if (last) eval_line(line_buf, 1'b0, cyc + 1);
        end
        if (last) begin
            model_done = 1'b1;
            done_cyc   = cyc + 1;
        end
    endtask

    always @(negedge clk) begin
        strobe_t a;
        strobe_t e;
        if (rst_n) begin
            if (valid === 1'b1) begin
                a = '{step_direction, int'(step_count), cyc};
                seen_q.push_back(a);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got dir %0d count %0d at cycle %0d, required no strobe",
                             step_direction, step_count, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_dir", step_direction, e.dir);
                    check("strobe_count", step_count, e.cnt);
                    check("strobe_cycle", cyc, e.cyc);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_strobe: got none at cycle %0d, required dir %0d count %0d",
                         cyc, exp_q[0].dir, exp_q[0].cnt);
                void'(exp_q.pop_front());
            end
            check("done", done, (done_cyc >= 0 && cyc >= done_cyc));
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        model_byte(b, last);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_at_end, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) idle(int'($urandom_range(0, 2)));
            send_byte(s[i], last_at_end && (i == s.len() - 1));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_dir"}, step_direction, 0);
        check({tag, "_count"}, step_count, 0);
        check({tag, "_done"}, done, 0);
`ifdef AOC_PARSER_ERR_EN
        check({tag, "_parse_error"}, parse_error, 0);
`endif
    endtask

    task automatic do_reset();
        exp_q.delete();
        line_buf   = "";
        model_done = 1'b0;
        done_cyc   = -1;
        exp_err    = 1'b0;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_q.delete();
    endtask

    task automatic check_nseen(input string tag, input int n);
        check({tag, "_strobes"}, seen_q.size(), n);
    endtask

    task automatic check_seen(input string tag, input int idx, input bit d, input int c);
        if (idx < seen_q.size()) begin
            check({tag, "_dir"}, seen_q[idx].dir, d);
            check({tag, "_count"}, seen_q[idx].cnt, c);
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: got no strobe #%0d, required dir %0d count %0d", tag, idx, d, c);
        end
    endtask

    task automatic check_err(input string tag);
`ifdef AOC_PARSER_ERR_EN
        check({tag, "_parse_error"}, parse_error, exp_err);
`else
        check({tag, "_model_err"}, exp_err, 0);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;
        idle(2);

        send_str("L68\nR30\n", 1'b0, 1'b0);
        idle(4);
        check_nseen("t1", 2);
        check_seen("t1_s0", 0, 1'b0, 68);
        check_seen("t1_s1", 1, 1'b1, 30);
        if (seen_q.size() == 2) check("t1_spacing", seen_q[1].cyc - seen_q[0].cyc, 4);

        do_reset();
        send_str("\n\015\nL0\015\nR007\n", 1'b0, 1'b1);
        idle(4);
        check_nseen("t2", 2);
        check_seen("t2_s0", 0, 1'b0, 0);
        check_seen("t2_s1", 1, 1'b1, 7);

        do_reset();
        send_str("R1500\nL2\n", 1'b0, 1'b0);
        idle(4);
        check_err("t3");
`ifdef AOC_PARSER_ERR_EN
        check_nseen("t3", 1);
        check_seen("t3_s0", 0, 1'b0, 2);
        check("t3_parse_error_lit", parse_error, 1);
`else
        check_nseen("t3", 2);
        check_seen("t3_s0", 0, 1'b1, 1023);
        check_seen("t3_s1", 1, 1'b0, 2);
`endif

        do_reset();
        send_str("LX4\n", 1'b0, 1'b0);
        idle(4);
        check_err("t4");
`ifdef AOC_PARSER_ERR_EN
        check_nseen("t4", 0);
        check("t4_parse_error_lit", parse_error, 1);
`else
        check_nseen("t4", 1);
        check_seen("t4_s0", 0, 1'b0, 4);
`endif

        do_reset();
        send_str("L1023\nR1024\nL00001\nR1\nL2\nL\n", 1'b0, 1'b0);
        idle(4);
        check_err("t5");
        check_seen("t5_s0", 0, 1'b0, 1023);
`ifdef AOC_PARSER_ERR_EN
        check_nseen("t5", 3);
        check_seen("t5_s1", 1, 1'b1, 1);
`else
        check_nseen("t5", 6);
        check_seen("t5_s1", 1, 1'b1, 1023);
        check_seen("t5_s2", 2, 1'b0, 1023);
        check_seen("t5_s5", 5, 1'b0, 0);
`endif

        do_reset();
        send_str("L3\nR12", 1'b0, 1'b0);
        idle(2);
        check_seen("t6_pre", 0, 1'b0, 3);
        do_reset();
        send_str("L3\n", 1'b0, 1'b0);
        idle(4);
        check_nseen("t6", 1);
        check_seen("t6_s0", 0, 1'b0, 3);

        do_reset();
        check("t7_done_before", done, 0);
        send_str("R999", 1'b1, 1'b0);
        check("t7_valid_done", {valid, done}, 2'b11);
        send_str("L5\n", 1'b0, 1'b0);
        idle(4);
        check_nseen("t7", 1);
        check_seen("t7_s0", 0, 1'b1, 999);
        check("t7_done_sticky", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
